addsub_seq: RTL and testbench



---
 rtl/addsub_pkg.sv | 19 +
 rtl/addsub_chunk.sv | 18 +
 rtl/addsub_seq.sv | 183 ++++++++++++++++++
 tb/tb_addsub_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the chunked adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit chunk_fits(input int width, input int chunk);
        return (chunk > 0) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder slice shared by the ADD and NEG passes.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    logic [CHUNK:0] full;

    assign full   = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
    assign sum_o  = full[CHUNK-1:0];
    assign cout_o = full[CHUNK];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle, optional magnitude pass,
// flags committed together with Result when the operation completes.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CHUNK     = 4,
    parameter int MAGNITUDE = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    input  logic             Signed,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Sign,
    output logic             Overflow,
    output logic             Zero
);

    localparam int N  = num_chunks(WIDTH, CHUNK);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

    if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_chunk
        $error("addsub_seq: WIDTH must be a positive multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic             sub_q, sub_d, sgn_q, sgn_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d, sign_q, sign_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
    logic             ch_cout, last, r_msb, s_ovf, add_ovf, add_sign, neg_go;
    logic [WIDTH-1:0] acc_wr;

    assign base = 32'(idx_q) * 32'(CHUNK);
    assign last = (idx_q == IW'(N - 1));

    // NEG reuses the adder as ~acc + 0 + carry, with carry seeded to 1.
    always_comb begin
        if (state_q == NEG) begin
            ch_a = ~CHUNK'(acc_q >> base);
            ch_b = '0;
        end else begin
            ch_a = CHUNK'(a_q >> base);
            ch_b = CHUNK'(b_q >> base);
        end
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i   (ch_a),
        .b_i   (ch_b),
        .cin_i (carry_q),
        .sum_o (ch_sum),
        .cout_o(ch_cout)
    );

    assign acc_wr = (acc_q & ~(CMASK << base)) | (WIDTH'(ch_sum) << base);

    // Flags from the ADD-pass result; only meaningful on the last ADD chunk.
    assign r_msb    = acc_wr[WIDTH-1];
    assign s_ovf    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_msb != a_q[WIDTH-1]);
    assign add_ovf  = sgn_q ? s_ovf : (sub_q ? 1'b0 : ch_cout);
    assign add_sign = sgn_q ? (r_msb ^ s_ovf) : (sub_q ? ~ch_cout : 1'b0);
    assign neg_go   = (MAGNITUDE != 0) && !sgn_q && sub_q && !ch_cout;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        sgn_d    = sgn_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (Start) begin
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    sub_d   = Sub;
                    sgn_d   = Signed;
                    carry_d = Sub;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                acc_d   = acc_wr;
                carry_d = ch_cout;
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    idx_d = '0;
                    if (neg_go) begin
                        carry_d = 1'b1;
                        state_d = NEG;
                    end else begin
                        result_d = acc_wr;
                        cout_d   = ch_cout;
                        sign_d   = add_sign;
                        ovf_d    = add_ovf;
                        zero_d   = (acc_wr == '0);
                        state_d  = DONE;
                    end
                end
            end
            NEG: begin
                acc_d   = acc_wr;
                carry_d = ch_cout;
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    // NEG only follows an unsigned borrow: Cout=0, Sign=1, no overflow.
                    idx_d    = '0;
                    result_d = acc_wr;
                    cout_d   = 1'b0;
                    sign_d   = 1'b1;
                    ovf_d    = 1'b0;
                    zero_d   = (acc_wr == '0);
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            sgn_q    <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            sgn_q    <= sgn_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign Busy     = (state_q == ADD) || (state_q == NEG);
    assign Done     = (state_q == DONE);
    assign Result   = result_q;
    assign Cout     = cout_q;
    assign Sign     = sign_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Random + directed check of two 8-bit/4-bit-chunk instances (MAGNITUDE 1 and 0)
// against an arithmetic reference model.
module tb_addsub_seq;

    logic       Clk = 1'b0;
    logic       Reset, Start, Sub, Sgn;
    logic [7:0] A, B;
    logic       bsy1, dn1, co1, sg1, ov1, zr1;
    logic       bsy0, dn0, co0, sg0, ov0, zr0;
    logic [7:0] r1, r0;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 Clk = ~Clk;

    addsub_seq #(.WIDTH(8), .CHUNK(4), .MAGNITUDE(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .Sub(Sub), .Signed(Sgn),
        .Busy(bsy1), .Done(dn1), .Result(r1), .Cout(co1), .Sign(sg1), .Overflow(ov1), .Zero(zr1)
    );

    addsub_seq #(.WIDTH(8), .CHUNK(4), .MAGNITUDE(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .Sub(Sub), .Signed(Sgn),
        .Busy(bsy0), .Done(dn0), .Result(r0), .Cout(co0), .Sign(sg0), .Overflow(ov0), .Zero(zr0)
    );

    typedef struct {
        logic [7:0] res;
        logic       cout, sign, ovf, zero;
        int         lat;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic sub, input logic sgn, input bit mag);
        exp_t e;
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int t;
        e.lat  = 2;
        e.cout = sub ? (ua >= ub) : (ua + ub > 255);
        if (sgn) begin
            t      = sub ? sa - sb : sa + sb;
            e.ovf  = (t > 127) || (t < -128);
            e.sign = (t < 0);
        end else if (!sub) begin
            t      = ua + ub;
            e.ovf  = e.cout;
            e.sign = 1'b0;
        end else begin
            t      = ua - ub;
            e.ovf  = 1'b0;
            e.sign = (t < 0);
            if (mag && t < 0) begin
                t     = -t;
                e.lat = 4;
            end
        end
        e.res  = t[7:0];
        e.zero = (e.res == 8'd0);
        return e;
    endfunction

    function automatic logic [11:0] pk(input exp_t e);
        return {e.res, e.cout, e.sign, e.ovf, e.zero};
    endfunction

    function automatic logic [13:0] obs1();
        return {bsy1, dn1, r1, co1, sg1, ov1, zr1};
    endfunction

    function automatic logic [13:0] obs0();
        return {bsy0, dn0, r0, co0, sg0, ov0, zr0};
    endfunction

    // One operation; poke pulses Start during ADD, which must be ignored.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic sgn, input bit poke);
        exp_t e1, e0;
        int c1 = 0, c0 = 0, n1 = 0, n0 = 0;
        logic [11:0] g1 = '0, g0 = '0;
        e1 = model(a, b, sub, sgn, 1'b1);
        e0 = model(a, b, sub, sgn, 1'b0);
        @(negedge Clk);
        A = a; B = b; Sub = sub; Sgn = sgn; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; A = 8'($urandom); B = 8'($urandom); Sub = ~sub;
        chk("busy", {30'd0, bsy1, bsy0}, 32'd3);
        for (int c = 1; c <= 7; c++) begin
            @(posedge Clk); #1;
            if (poke && c <= 2) Start = (c == 1);
            if (dn1) begin n1++; if (c1 == 0) begin c1 = c; g1 = {r1, co1, sg1, ov1, zr1}; end end
            if (dn0) begin n0++; if (c0 == 0) begin c0 = c; g0 = {r0, co0, sg0, ov0, zr0}; end end
        end
        chk("lat_mag1", c1, e1.lat);
        chk("lat_mag0", c0, e0.lat);
        chk("done_pulses", n1 * 16 + n0, 17);
        chk("out_mag1", g1, pk(e1));
        chk("out_mag0", g0, pk(e0));
        chk("hold_mag1", {r1, co1, sg1, ov1, zr1}, pk(e1));
    endtask

    task automatic run_b2b(input logic [7:0] a1, input logic [7:0] b1,
                           input logic [7:0] a2, input logic [7:0] b2);
        exp_t e1, e2;
        logic [8:0] pat1 = '0, pat0 = '0;
        logic [11:0] g_first = '0, g_second = '0;
        e1 = model(a1, b1, 1'b0, 1'b0, 1'b1);
        e2 = model(a2, b2, 1'b0, 1'b1, 1'b1);
        @(negedge Clk);
        A = a1; B = b1; Sub = 1'b0; Sgn = 1'b0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge Clk); #1;
            pat1[c] = dn1;
            pat0[c] = dn0;
            if (c == 2) begin
                g_first = {r1, co1, sg1, ov1, zr1};
                A = a2; B = b2; Sub = 1'b0; Sgn = 1'b1; Start = 1'b1;
            end
            if (c == 3) Start = 1'b0;
            if (c == 5) g_second = {r1, co1, sg1, ov1, zr1};
        end
        chk("b2b_pat_mag1", pat1, 9'b000100100);
        chk("b2b_pat_mag0", pat0, 9'b000100100);
        chk("b2b_first", g_first, pk(e1));
        chk("b2b_second", g_second, pk(e2));
    endtask

    initial begin
        int nd;
        Reset = 1'b1; Start = 1'b0; A = '0; B = '0; Sub = 1'b0; Sgn = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_mag1", obs1(), 14'd0);
        chk("reset_mag0", obs0(), 14'd0);
        @(negedge Clk);
        Reset = 1'b0;

        run_op(8'd200, 8'd100, 1'b0, 1'b0, 1'b0);
        run_op(8'd5,   8'd9,   1'b1, 1'b0, 1'b0);
        run_op(8'd100, 8'd50,  1'b0, 1'b1, 1'b0);
        run_op(8'h80,  8'h01,  1'b1, 1'b1, 1'b0);
        run_op(8'd77,  8'd77,  1'b1, 1'b0, 1'b0);
        run_op(8'h00,  8'h00,  1'b0, 1'b1, 1'b0);
        run_op(8'h7F,  8'hFF,  1'b1, 1'b1, 1'b0);
        run_op(8'h00,  8'hFF,  1'b1, 1'b0, 1'b0);
        run_op(8'd10,  8'd3,   1'b1, 1'b0, 1'b1);
        run_op(8'd3,   8'd10,  1'b1, 1'b0, 1'b1);
        run_b2b(8'd17, 8'd250, 8'h70, 8'h20);

        for (int i = 0; i < 40; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0);

        // Reset in the first ADD cycle aborts the operation.
        @(negedge Clk);
        A = 8'd9; B = 8'd200; Sub = 1'b1; Sgn = 1'b0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort_mag1", obs1(), 14'd0);
        chk("abort_mag0", obs0(), 14'd0);
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clk); #1;
            nd += int'(dn1) + int'(dn0) + int'(bsy1) + int'(bsy0);
        end
        chk("abort_quiet", nd, 0);

        // Reset and Start together: Reset wins.
        @(negedge Clk);
        A = 8'd1; B = 8'd2; Sub = 1'b0; Start = 1'b1; Reset = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge Clk); #1;
            nd += int'(dn1) + int'(dn0) + int'(bsy1) + int'(bsy0);
        end
        chk("rst_start_quiet", nd, 0);

        run_op(8'd1, 8'd2, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
